// File: rtl/uart_tx_ctrl.sv
// MMIO transmit controller: queues 32-bit CPU stores in a small word FIFO
// and feeds them MSB-first, one byte at a time, to the UART transmitter.
module uart_tx_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] TX_ADDR   = 32'h0000_7EEF,
  parameter logic [31:0] STAT_ADDR = 32'h0000_7EF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] rdata,
  input  logic        tx_busy,
  output logic        tx_ena,
  output logic [7:0]  tx_data,
  output logic        full,
  output logic        empty,
  output logic        drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     hold_q, hold_d;
  logic [1:0]      idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic            tx_ena_q, tx_ena_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            drained_q, drained_d;

  logic            wr_req;
  logic            ctl_wr;
  logic            push;
  logic            pop;
  logic [31:0]     head;
  logic [1:0]      idx_nx;
  logic [31:0]     stat;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] sel_byte(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return w[{~i, 3'b000} +: 8];
  endfunction

  assign wr_req = we && (address == TX_ADDR);
  assign ctl_wr = we && (address == STAT_ADDR);
  assign push   = wr_req && (count_q < CW'(DEPTH));
  assign pop    = (state_q == IDLE) && (count_q != '0);
  assign head   = mem_q[rptr_q];
  assign idx_nx = idx_q + 2'd1;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q;
    if (push) begin
      mem_d[wptr_q] = dataIn;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    // A write on full is dropped even if a pop happens on the same edge.
    if (wr_req && !push) begin
      ovf_d = 1'b1;
    end else if (ctl_wr && dataIn[3]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    tx_ena_d  = 1'b0;
    tx_data_d = tx_data_q;
    drained_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          hold_d    = head;
          idx_d     = 2'd0;
          tx_data_d = head[31:24];
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_ena_d = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!tx_busy) begin
          if (idx_q != 2'd3) begin
            idx_d     = idx_nx;
            tx_data_d = sel_byte(hold_q, idx_nx);
            state_d   = SEND;
          end else begin
            state_d   = IDLE;
            drained_d = (count_q == '0) && !wr_req;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      tx_ena_q  <= 1'b0;
      tx_data_q <= '0;
      drained_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      tx_ena_q  <= tx_ena_d;
      tx_data_q <= tx_data_d;
      drained_q <= drained_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    stat          = '0;
    stat[0]       = full;
    stat[1]       = empty;
    stat[2]       = (state_q != IDLE);
    stat[3]       = ovf_q;
    stat[8 +: CW] = count_q;
  end

  assign rdata   = (address == STAT_ADDR) ? stat : 32'h0;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign tx_ena  = tx_ena_q;
  assign tx_data = tx_data_q;
  assign drained = drained_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a byte scoreboard
// and a UART model that stays busy 10 cycles per byte.
module tb_uart_tx_ctrl;

  localparam logic [31:0] TXA = 32'h0000_7EEF;
  localparam logic [31:0] STA = 32'h0000_7EF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] rdata;
  logic        tx_busy;
  logic        tx_ena;
  logic [7:0]  tx_data;
  logic        full;
  logic        empty;
  logic        drained;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  int          ena_cnt = 0;
  int          drn_cnt = 0;
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;

  uart_tx_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .address (address),
    .dataIn  (dataIn),
    .rdata   (rdata),
    .tx_busy (tx_busy),
    .tx_ena  (tx_ena),
    .tx_data (tx_data),
    .full    (full),
    .empty   (empty),
    .drained (drained)
  );

  always #5 clk = ~clk;

  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    we      = 1'b1;
    address = a;
    dataIn  = d;
    @(negedge clk);
    we      = 1'b0;
    address = 32'h0;
    dataIn  = 32'h0;
  endtask

  task automatic wait_drain(input int lim);
    int d0;
    int n;
    d0 = drn_cnt;
    n  = 0;
    while (drn_cnt == d0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_seen", 32'(drn_cnt - d0), 32'd1);
  endtask

  // UART model plus output monitor.
  always @(negedge clk) begin
    logic have;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (tx_ena) begin
      ena_cnt  = ena_cnt + 1;
      busy_cnt = 10;
      have = (exp_q.size() > 0);
      chk("byte_expected", 32'(have), 32'd1);
      if (have) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (drained) begin
      drn_cnt = drn_cnt + 1;
      chk("drain_q_empty", 32'(exp_q.size()), 32'd0);
    end
  end

  initial begin
    int e0;
    int d0;
    int n;
    reset   = 1'b1;
    we      = 1'b0;
    address = 32'h0;
    dataIn  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx_ena", 32'(tx_ena), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    reset   = 1'b0;
    address = STA;
    #1 chk("rst_status", rdata, 32'h0000_0002);

    // single word, first-byte latency
    e0 = ena_cnt;
    push_word(32'hDEADBEEF);
    do_wr(TXA, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_edge1", 32'(tx_ena), 32'd0);
    @(negedge clk);
    chk("lat_edge2", 32'(tx_ena), 32'd1);
    chk("lat_byte", 32'(tx_data), 32'hDE);
    wait_drain(300);
    chk("w1_pulses", 32'(ena_cnt - e0), 32'd4);
    chk("w1_empty", 32'(empty), 32'd1);

    // enqueue on the same edge as the pop
    e0 = ena_cnt;
    d0 = drn_cnt;
    push_word(32'h11223344);
    push_word(32'h55667788);
    do_wr(TXA, 32'h11223344);
    do_wr(TXA, 32'h55667788);
    address = STA;
    #1 chk("samepop_stat", rdata, 32'h0000_0104);
    wait_drain(500);
    chk("samepop_pulses", 32'(ena_cnt - e0), 32'd8);
    chk("samepop_drn", 32'(drn_cnt - d0), 32'd1);

    // overflow while UART held busy
    force_busy = 1'b1;
    e0 = ena_cnt;
    push_word(32'hA0A1A2A3);
    do_wr(TXA, 32'hA0A1A2A3);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push_word(32'hB0000000 + 32'(k));
      do_wr(TXA, 32'hB0000000 + 32'(k));
    end
    address = STA;
    #1 chk("ovf_stat", rdata, 32'h0000_040D);
    chk("ovf_full", 32'(full), 32'd1);
    @(negedge clk);
    do_wr(STA, 32'h0000_0008);
    address = STA;
    #1 chk("ovf_clear", rdata, 32'h0000_0405);
    repeat (20) @(negedge clk);
    chk("busy_hold", 32'(ena_cnt - e0), 32'd0);
    force_busy = 1'b0;
    wait_drain(1500);
    chk("ovf_pulses", 32'(ena_cnt - e0), 32'd20);

    // reset in DONE at idx 2
    e0 = ena_cnt;
    push_word(32'hCAFEF00D);
    do_wr(TXA, 32'hCAFEF00D);
    n = 0;
    while (ena_cnt - e0 < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1 chk("rst_mid_reach", 32'(ena_cnt - e0), 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    address = STA;
    #1;
    chk("mid_tx_ena", 32'(tx_ena), 32'd0);
    chk("mid_tx_data", 32'(tx_data), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_stat", rdata, 32'h0000_0002);
    e0 = ena_cnt;
    d0 = drn_cnt;
    repeat (60) @(negedge clk);
    chk("mid_no_ena", 32'(ena_cnt - e0), 32'd0);
    chk("mid_no_drn", 32'(drn_cnt - d0), 32'd0);

    // 9 words through the FIFO, pointer wrap
    e0 = ena_cnt;
    for (int k = 0; k < 9; k++) begin
      n = 0;
      while (full && n < 200) begin
        @(negedge clk);
        n++;
      end
      push_word(32'h01020304 + 32'(k));
      do_wr(TXA, 32'h01020304 + 32'(k));
    end
    wait_drain(3000);
    chk("wrap_pulses", 32'(ena_cnt - e0), 32'd36);
    chk("wrap_q_left", 32'(exp_q.size()), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
